// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared slot-field widths, FSM encoding and timeout default for bus_fabric
package bus_pkg;

  localparam int WS_W       = 4;
  localparam int TMO_W      = 8;
  localparam int BOOT_CNT_W = 8;

  localparam logic [TMO_W-1:0] TIMEOUT_DEFAULT = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIXED = 2'd1,
    ST_SLAVE = 2'd2,
    ST_DONE  = 2'd3
  } bus_state_t;

endpackage

// File: rtl/bus_if.sv
// rtl/bus_if.sv - CPU strobes, slave channels and fabric status bundled as one port
interface bus_if #(
  parameter int N_SLV = 6,
  parameter int AW    = 16,
  parameter int DW    = 8
);

  logic [AW-1:0]       a;
  logic                mreq;
  logic                iorq;
  logic                rd;
  logic                wr;
  logic [N_SLV*DW-1:0] slv_do;
  logic [N_SLV-1:0]    slv_wait;
  logic [N_SLV-1:0]    sel;
  logic [DW-1:0]       di;
  logic                cpu_wait;
  logic                bus_err;
  logic [AW-1:0]       err_addr;

  modport master (
    output a, mreq, iorq, rd, wr, slv_do, slv_wait,
    input  sel, di, cpu_wait, bus_err, err_addr
  );

  modport slave (
    input  a, mreq, iorq, rd, wr, slv_do, slv_wait,
    output sel, di, cpu_wait, bus_err, err_addr
  );

endinterface

// File: rtl/bus_region_decode.sv
// rtl/bus_region_decode.sv - priority address/space decode with bootstrap read overlay
module bus_region_decode #(
  parameter int                  N_SLV     = 6,
  parameter int                  AW        = 16,
  parameter logic [N_SLV*AW-1:0] BASE      = '0,
  parameter logic [N_SLV*AW-1:0] MASK      = '0,
  parameter logic [N_SLV-1:0]    IO_SPACE  = '0,
  parameter int                  BOOT_SLOT = 0
) (
  input  logic [AW-1:0]    a,
  input  logic             mreq,
  input  logic             iorq,
  input  logic             rd,
  input  logic             boot_active,
  output logic [N_SLV-1:0] sel
);

  logic found;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    if (boot_active && mreq && rd) begin
      sel[BOOT_SLOT] = 1'b1;
    end else begin
      // ascending scan with a found flag gives lowest-index priority
      for (int i = 0; i < N_SLV; i++) begin
        if (!found && ((a & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) &&
            (IO_SPACE[i] ? iorq : mreq)) begin
          sel[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// rtl/bus_fabric.sv - CPU-to-slave fabric: decode, fixed/slave wait sequencing, timeout, boot overlay
module bus_fabric
  import bus_pkg::*;
#(
  parameter int                    N_SLV     = 6,
  parameter int                    AW        = 16,
  parameter int                    DW        = 8,
  parameter logic [N_SLV*AW-1:0]   BASE      = '0,
  parameter logic [N_SLV*AW-1:0]   MASK      = '0,
  parameter logic [N_SLV-1:0]      IO_SPACE  = '0,
  parameter logic [N_SLV*WS_W-1:0] WS        = '0,
  parameter int                    BOOT_SLOT = 0,
  parameter int                    BOOT_LEN  = 3,
  parameter logic [TMO_W-1:0]      TIMEOUT   = TIMEOUT_DEFAULT
) (
  input logic  clk,
  input logic  rst,
  bus_if.slave bus
);

  localparam logic [BOOT_CNT_W-1:0] BOOT_LAST = BOOT_CNT_W'(BOOT_LEN - 1);

  bus_state_t            state, state_n;
  logic [WS_W-1:0]       cnt, cnt_n, ws_sel;
  logic [TMO_W-1:0]      tcnt, tcnt_n;
  logic [BOOT_CNT_W-1:0] boot_cnt;
  logic                  boot_active;
  logic                  err_flag;
  logic [AW-1:0]         err_addr;
  logic [N_SLV-1:0]      sel;
  logic [DW-1:0]         slot_do;
  logic                  hit, sw, strobe;
  logic                  raw_wait, active, complete, timeout;

  bus_region_decode #(
    .N_SLV    (N_SLV),
    .AW       (AW),
    .BASE     (BASE),
    .MASK     (MASK),
    .IO_SPACE (IO_SPACE),
    .BOOT_SLOT(BOOT_SLOT)
  ) u_decode (
    .a          (bus.a),
    .mreq       (bus.mreq),
    .iorq       (bus.iorq),
    .rd         (bus.rd),
    .boot_active(boot_active),
    .sel        (sel)
  );

  always_comb begin
    ws_sel  = '0;
    sw      = 1'b0;
    slot_do = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel[i]) begin
        ws_sel  = WS[i*WS_W +: WS_W];
        sw      = bus.slv_wait[i];
        slot_do = bus.slv_do[i*DW +: DW];
      end
    end
  end

  assign hit    = |sel;
  assign strobe = bus.rd | bus.wr;

  // The start cycle is the first wait cycle, and the last fixed count
  // doubles as the first slave-wait sample, so WAIT spans max(WS, slave wait).
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    raw_wait = 1'b0;
    active   = 1'b0;
    complete = 1'b0;
    case (state)
      ST_IDLE: begin
        if (strobe && hit) begin
          active = 1'b1;
          if (ws_sel != '0) begin
            raw_wait = 1'b1;
            cnt_n    = ws_sel;
            state_n  = ST_FIXED;
          end else begin
            raw_wait = sw;
            state_n  = ST_SLAVE;
          end
        end
      end
      ST_FIXED: begin
        if (!strobe) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          active = 1'b1;
          if (cnt > WS_W'(1)) begin
            raw_wait = 1'b1;
            cnt_n    = cnt - 1'b1;
          end else begin
            raw_wait = sw;
            cnt_n    = '0;
            complete = !sw;
            state_n  = sw ? ST_SLAVE : ST_DONE;
          end
        end
      end
      ST_SLAVE: begin
        if (!strobe) begin
          state_n = ST_IDLE;
        end else begin
          active   = 1'b1;
          raw_wait = sw;
          complete = !sw;
          if (!sw) state_n = ST_DONE;
        end
      end
      default: begin
        if (!strobe) state_n = ST_IDLE;
      end
    endcase

    timeout = active && raw_wait && (tcnt == TIMEOUT) && !rst;
    if (timeout) begin
      complete = 1'b0;
      cnt_n    = '0;
      state_n  = ST_DONE;
    end
    tcnt_n = (active && raw_wait && !timeout) ? tcnt + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      tcnt        <= '0;
      boot_cnt    <= '0;
      boot_active <= 1'b1;
      err_flag    <= 1'b0;
      err_addr    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      tcnt  <= tcnt_n;
      if (timeout) begin
        err_flag <= 1'b1;
        err_addr <= bus.a;
      end else if (state_n == ST_IDLE) begin
        err_flag <= 1'b0;
      end
      if (complete && boot_active && bus.mreq && bus.rd) begin
        boot_cnt <= boot_cnt + 1'b1;
        if (boot_cnt == BOOT_LAST) boot_active <= 1'b0;
      end
    end
  end

  assign bus.sel      = sel;
  assign bus.di       = (!hit || err_flag || timeout) ? '1 : slot_do;
  assign bus.cpu_wait = raw_wait && !timeout && !rst;
  assign bus.bus_err  = timeout;
  assign bus.err_addr = err_addr;

endmodule

// File: doc/bus_fabric.md
BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 SHALL have parameter N_SLV, default 6, number of slave channels (1..16).
REQ-002 SHALL have parameter AW, default 16, address width.
REQ-003 SHALL have parameter DW, default 8, data width.
REQ-004 SHALL have parameter BASE, default all-zero, N_SLV x AW packed match values, slot 0 at LSBs.
REQ-005 SHALL have parameter MASK, default all-zero, N_SLV x AW packed match masks.
REQ-006 SHALL have parameter IO_SPACE, default 0, N_SLV bits; 1 = slot decodes IORQ, 0 = slot decodes MREQ.
REQ-007 SHALL have parameter WS, default 0, N_SLV x 4 packed fixed wait states per slot.
REQ-008 SHALL have parameter BOOT_SLOT, default 0, slot forced during bootstrap overlay.
REQ-009 SHALL have parameter BOOT_LEN, default 3, completed memory reads served by overlay.
REQ-010 SHALL have parameter TIMEOUT, default 255, maximum consecutive WAIT cycles (8-bit).
REQ-011 CLK  in  1  system clock; RESET  in  1  asynchronous active-high reset.
REQ-012 A  in  AW  CPU address; MREQ, IORQ, RD, WR  in  1 each  active-high CPU strobes.
REQ-013 SLV_DO  in  N_SLV x DW  slave read data; SLV_WAIT  in  N_SLV  slave wait requests.
REQ-014 SEL  out  N_SLV  one-hot slave select (combinational).
REQ-015 DI  out  DW  CPU read data; WAIT  out  1  CPU wait.
REQ-016 BUS_ERR  out  1  one-cycle timeout pulse; ERR_ADDR  out  AW  address of last timeout.

Function
REQ-017 Slot i SHALL match when (A & MASK_i) == BASE_i and the strobe selected by IO_SPACE[i] is high; lowest matching index wins.
REQ-018 While boot_active, every MREQ read SHALL select BOOT_SLOT only, regardless of A; writes and IO decode normally.
REQ-019 boot_active SHALL clear in the cycle after the BOOT_LEN-th completed memory read; it never re-sets except by RESET.
REQ-020 No match SHALL give SEL = 0, DI = all-ones, WAIT = 0.
REQ-021 DI SHALL equal SLV_DO of the selected slot, combinationally.
REQ-022 FSM states: IDLE, FIXED, SLAVE, DONE.
REQ-023 IDLE -> FIXED when RD or WR high with a matched slot and WS_sel != 0; counter loads WS_sel; WAIT = 1.
REQ-024 IDLE -> SLAVE when RD or WR high with a matched slot and WS_sel == 0.
REQ-025 FIXED: counter decrements per cycle; at 1 -> SLAVE; WAIT = 1 throughout.
REQ-026 SLAVE: WAIT = SLV_WAIT[sel]; when SLV_WAIT[sel] is low -> DONE; the access is counted complete here.
REQ-027 DONE: WAIT = 0; -> IDLE when RD and WR both low; a new strobe without a prior low cycle does not start an access.
REQ-028 Timeout counter SHALL count consecutive WAIT=1 cycles; on reaching TIMEOUT: force WAIT = 0, DI = all-ones for that access, BUS_ERR = 1 for one cycle, ERR_ADDR <= A, -> DONE.
REQ-029 Strobes dropping mid-FIXED/SLAVE SHALL abort to IDLE without counting completion or raising BUS_ERR.
REQ-030 Unmatched accesses SHALL count toward BOOT_LEN only if they are memory reads during boot_active (always matched by REQ-018).

Reset
REQ-031 RESET SHALL force FSM = IDLE, counters = 0, boot_active = 1, BUS_ERR = 0, ERR_ADDR = 0, WAIT = 0 asynchronously.
REQ-032 RESET asserted mid-access SHALL abandon the access; no BUS_ERR on release.

Structure
REQ-033 Slot-field widths, FSM state encoding and the default TIMEOUT SHALL live in shared package bus_pkg.
REQ-034 Decode SHALL be sub-module bus_region_decode (A, MREQ, IORQ, boot_active -> one-hot SEL); sequencing stays in bus_fabric.

Verification
REQ-035 Reset, three memory reads at 0x0000, 0x0001, 0x0002 -> SEL[BOOT_SLOT]; fourth read at 0x0000 decodes by BASE/MASK.
REQ-036 Slot with WS=3, SLV_WAIT=0, RD held -> WAIT high exactly 3 cycles, then DI = SLV_DO.
REQ-037 Slot WS=0, SLV_WAIT high 5 cycles -> WAIT high 5 cycles, drops with SLV_WAIT.
REQ-038 TIMEOUT=10, SLV_WAIT stuck high at A=0xE123 -> WAIT low on 11th cycle, BUS_ERR one pulse, ERR_ADDR = 0xE123, DI = 0xFF.
REQ-039 Read of unmapped 0x9000 -> SEL = 0, DI = 0xFF, WAIT = 0; IORQ read of mem-only slot address -> same.
REQ-040 RESET pulsed during FIXED count -> WAIT = 0, boot_active = 1, next reads served by BOOT_SLOT.
